// File: rtl/vip_src_pkg.sv
// Shared definitions for the VIP frame source: packet type codes, FSM state
// encoding and the nibble-to-symbol packing used by control-packet beats.
package vip_src_pkg;

  localparam logic [3:0] VIP_PKT_CTRL  = 4'hF;
  localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;

  localparam int SYM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CTRL_HDR = 3'd1,
    S_CTRL_D0  = 3'd2,
    S_CTRL_D1  = 3'd3,
    S_CTRL_D2  = 3'd4,
    S_VID_HDR  = 3'd5,
    S_VID_DATA = 3'd6,
    S_DONE     = 3'd7
  } src_state_e;

  // Control-packet symbols carry one nibble in the low bits, upper bits zero.
  function automatic logic [SYM_W-1:0] nib_sym(input logic [3:0] nib);
    return {{(SYM_W-4){1'b0}}, nib};
  endfunction

endpackage

// File: rtl/vip_src_test_pattern.sv
// Eight-bar colour generator: bar index = col*8/w_lat, white first, black last.
// Pixels are {sym2, sym1, sym0} = {R, G, B}.
module vip_src_test_pattern #(
  parameter int DW = 24
) (
  input  logic [15:0]   i_col,
  input  logic [15:0]   i_w_lat,
  output logic [DW-1:0] o_pixel
);

  logic [18:0] w_scaled;
  logic [18:0] w_quot;
  logic [2:0]  w_bar;

  assign w_scaled = {i_col, 3'b000};
  // col < w_lat during a frame, so the quotient always lands in 0..7.
  assign w_quot   = (i_w_lat == 16'd0) ? 19'd0 : (w_scaled / {3'b000, i_w_lat});
  assign w_bar    = w_quot[2:0];

  // Bar index to colour lookup.
  always_comb begin
    o_pixel = '0;
    case (w_bar)
      3'd0:    o_pixel = DW'(24'hFFFFFF); // white
      3'd1:    o_pixel = DW'(24'hFFFF00); // yellow
      3'd2:    o_pixel = DW'(24'h00FFFF); // cyan
      3'd3:    o_pixel = DW'(24'h00FF00); // green
      3'd4:    o_pixel = DW'(24'hFF00FF); // magenta
      3'd5:    o_pixel = DW'(24'hFF0000); // red
      3'd6:    o_pixel = DW'(24'h0000FF); // blue
      default: o_pixel = DW'(24'h000000); // black
    endcase
  end

endmodule

// File: rtl/vip_frame_source.sv
// Avalon-ST VIP frame transmitter: one control packet then one video packet
// per accepted start. Pixels come from the pix_* interface, or, when
// VIP_SRC_TEST_PATTERN_EN is defined, from an internal 8-bar generator.
module vip_frame_source
  import vip_src_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [15:0]                               width,
  input  logic [15:0]                               height,
  input  logic [3:0]                                interlaced,
  input  logic                                      pix_valid,
  output logic                                      pix_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] pix_data,
  input  logic                                      dout_ready,
  output logic                                      dout_valid,
  output logic                                      dout_sop,
  output logic                                      dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                      busy,
  output logic                                      frame_done
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  src_state_e r_state;
  src_state_e w_next_state;

  logic [15:0] r_w_lat;
  logic [15:0] r_h_lat;
  logic [3:0]  r_il_lat;
  logic [15:0] r_col;
  logic [15:0] r_row;

  logic          w_start_ok;
  logic          w_last;
  logic          w_xfer;
  logic          w_src_valid;
  logic          w_src_ready;
  logic [DW-1:0] w_src_data;

  // Three symbols, symbol 0 in the LSBs.
  function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] s0,
                                              input logic [3:0] s1,
                                              input logic [3:0] s2);
    return DW'({nib_sym(s2), nib_sym(s1), nib_sym(s0)});
  endfunction

  assign w_start_ok = start && (width != 16'd0) && (height != 16'd0);
  assign w_last     = (r_col == r_w_lat - 16'd1) && (r_row == r_h_lat - 16'd1);
  assign w_xfer     = dout_valid && dout_ready;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

`ifdef VIP_SRC_TEST_PATTERN_EN
  logic [DW-1:0] w_tp_pixel;

  vip_src_test_pattern #(.DW(DW)) u_test_pattern (
    .i_col   (r_col),
    .i_w_lat (r_w_lat),
    .o_pixel (w_tp_pixel)
  );

  // Generator is always ready to supply; the external pixel port stays idle.
  assign w_src_valid = 1'b1;
  assign w_src_data  = w_tp_pixel;
  assign w_src_ready = 1'b0;
`else
  assign w_src_valid = pix_valid;
  assign w_src_data  = pix_data;
  assign w_src_ready = dout_ready;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and beat outputs; outputs depend only on registered state and live inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_next_state = r_state;
    dout_valid   = 1'b0;
    dout_sop     = 1'b0;
    dout_eop     = 1'b0;
    dout_data    = '0;
    pix_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_CTRL_HDR;
      end
      S_CTRL_HDR: begin
        dout_valid = 1'b1;
        dout_sop   = 1'b1;
        dout_data  = ctrl_beat(VIP_PKT_CTRL, 4'h0, 4'h0);
        if (dout_ready) w_next_state = S_CTRL_D0;
      end
      S_CTRL_D0: begin
        dout_valid = 1'b1;
        dout_data  = ctrl_beat(r_w_lat[15:12], r_w_lat[11:8], r_w_lat[7:4]);
        if (dout_ready) w_next_state = S_CTRL_D1;
      end
      S_CTRL_D1: begin
        dout_valid = 1'b1;
        dout_data  = ctrl_beat(r_w_lat[3:0], r_h_lat[15:12], r_h_lat[11:8]);
        if (dout_ready) w_next_state = S_CTRL_D2;
      end
      S_CTRL_D2: begin
        dout_valid = 1'b1;
        dout_eop   = 1'b1;
        dout_data  = ctrl_beat(r_h_lat[7:4], r_h_lat[3:0], r_il_lat);
        if (dout_ready) w_next_state = S_VID_HDR;
      end
      S_VID_HDR: begin
        dout_valid = 1'b1;
        dout_sop   = 1'b1;
        dout_data  = ctrl_beat(VIP_PKT_VIDEO, 4'h0, 4'h0);
        if (dout_ready) w_next_state = S_VID_DATA;
      end
      S_VID_DATA: begin
        dout_valid = w_src_valid;
        dout_data  = w_src_data;
        dout_eop   = w_last;
        pix_ready  = w_src_ready;
        if (w_src_valid && dout_ready && w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Geometry is captured once per accepted start and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_lat  <= 16'd0;
      r_h_lat  <= 16'd0;
      r_il_lat <= 4'd0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_w_lat  <= width;
      r_h_lat  <= height;
      r_il_lat <= interlaced;
    end
  end

  // Column/row position, advanced only on video-data transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if ((r_state == S_VID_DATA) && w_xfer) begin
      if (r_col == r_w_lat - 16'd1) begin
        r_col <= 16'd0;
        r_row <= (r_row == r_h_lat - 16'd1) ? 16'd0 : r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

endmodule
